// File: rtl/cassette_record_if.sv
// SDRAM write port of the cassette record path: address/data/request with a
// one-cycle acknowledge from the arbiter.
interface cassette_record_if;
    logic [24:0] sdram_addr;
    logic [7:0]  sdram_dout;
    logic        sdram_wr;
    logic        sdram_ack;

    modport master (
        output sdram_addr,
        output sdram_dout,
        output sdram_wr,
        input  sdram_ack
    );

    modport slave (
        input  sdram_addr,
        input  sdram_dout,
        input  sdram_wr,
        output sdram_ack
    );
endinterface

// File: rtl/cassette_record.sv
// Cassette record path: measures FSK cycle periods on the ULA cassette output,
// decodes 1200/2400 Hz cycles into bits, frames 8N1 bytes and writes them
// sequentially into the SDRAM tape image.
module cassette_record #(
    parameter int unsigned MIN_PER      = 2000,
    parameter int unsigned THRESH       = 10000,
    parameter int unsigned MAX_PER      = 20000,
    parameter int unsigned CARRIER_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     rewind,
    input  logic                     cas_in,
    cassette_record_if.master        sdram,
    output logic                     carrier,
    output logic                     frame_err,
    output logic                     overflow,
    output logic [2:0]               status
);

    localparam logic [15:0] MinPerC = 16'(MIN_PER);
    localparam logic [15:0] ThreshC = 16'(THRESH);
    localparam logic [15:0] MaxPerC = 16'(MAX_PER);
    localparam int unsigned OnesW   = $clog2(CARRIER_BITS + 1);
    localparam logic [OnesW-1:0] OnesLast = OnesW'(CARRIER_BITS - 1);

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StLeader = 2'd1,
        StData   = 2'd2,
        StStop   = 2'd3
    } state_e;

    // sync_q[2] is the edge register holding the previous synchronised level
    logic [2:0]       sync_q;
    logic             rew_q;
    logic [15:0]      cnt_q;
    logic             sym_valid_q;
    logic             sym_long_q;
    logic             pend_q;
    logic             bit_valid_q;
    logic             bit_q;
    state_e           state_q;
    logic [OnesW-1:0] ones_q;
    logic [2:0]       idx_q;
    logic [7:0]       shreg_q;

    logic rise;
    logic edge_ok;
    logic timeout;
    logic rew_tog;

    assign rise    = sync_q[1] & ~sync_q[2];
    assign edge_ok = rise && (cnt_q >= MinPerC);
    // A valid edge in the timeout cycle is still classified; the framer resets anyway
    assign timeout = (cnt_q == MaxPerC);
    assign rew_tog = rewind ^ rew_q;

    assign carrier = (state_q != StHunt);
    assign status  = {1'b0, state_q};

    // Synchroniser, edge register and rewind toggle capture
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 3'b000;
            rew_q  <= rewind;
        end else begin
            sync_q <= {sync_q[1:0], cas_in};
            rew_q  <= rewind;
        end
    end

    // Period counter and short/long classification of each accepted cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            sym_valid_q <= 1'b0;
            sym_long_q  <= 1'b0;
        end else begin
            sym_valid_q <= 1'b0;
            if (edge_ok) begin
                cnt_q       <= '0;
                sym_valid_q <= 1'b1;
                sym_long_q  <= (cnt_q >= ThreshC);
            end else if (cnt_q != MaxPerC) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    // Bit decoder, byte framer and SDRAM write handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q            <= 1'b0;
            bit_valid_q       <= 1'b0;
            bit_q             <= 1'b0;
            state_q           <= StHunt;
            ones_q            <= '0;
            idx_q             <= 3'd0;
            shreg_q           <= 8'd0;
            frame_err         <= 1'b0;
            overflow          <= 1'b0;
            sdram.sdram_addr  <= 25'd0;
            sdram.sdram_dout  <= 8'd0;
            sdram.sdram_wr    <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            bit_valid_q <= 1'b0;

            if (sym_valid_q) begin
                if (sym_long_q) begin
                    bit_valid_q <= 1'b1;
                    bit_q       <= 1'b0;
                    pend_q      <= 1'b0;
                    // Long cycle arriving after an unpaired short one
                    if (pend_q) frame_err <= 1'b1;
                end else if (pend_q) begin
                    bit_valid_q <= 1'b1;
                    bit_q       <= 1'b1;
                    pend_q      <= 1'b0;
                end else begin
                    pend_q <= 1'b1;
                end
            end

            if (sdram.sdram_wr && sdram.sdram_ack) begin
                sdram.sdram_wr   <= 1'b0;
                sdram.sdram_addr <= sdram.sdram_addr + 25'd1;
            end

            if (!en) begin
                state_q <= StHunt;
                ones_q  <= '0;
            end else if (bit_valid_q) begin
                unique case (state_q)
                    StHunt: begin
                        if (!bit_q) begin
                            ones_q <= '0;
                        end else if (ones_q == OnesLast) begin
                            ones_q  <= '0;
                            state_q <= StLeader;
                        end else begin
                            ones_q <= ones_q + OnesW'(1);
                        end
                    end
                    StLeader: begin
                        if (!bit_q) begin
                            idx_q   <= 3'd0;
                            state_q <= StData;
                        end
                    end
                    StData: begin
                        shreg_q <= {bit_q, shreg_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) state_q <= StStop;
                    end
                    StStop: begin
                        if (bit_q) begin
                            if (!sdram.sdram_wr) begin
                                sdram.sdram_dout <= shreg_q;
                                sdram.sdram_wr   <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                            state_q <= StLeader;
                        end else begin
                            frame_err <= 1'b1;
                            state_q   <= StHunt;
                        end
                    end
                    default: state_q <= StHunt;
                endcase
            end

            if (timeout) begin
                state_q <= StHunt;
                ones_q  <= '0;
                pend_q  <= 1'b0;
            end

            // Rewind wins over everything, including a same-cycle ack
            if (rew_tog) begin
                sdram.sdram_addr <= 25'd0;
                sdram.sdram_wr   <= 1'b0;
                overflow         <= 1'b0;
                state_q          <= StHunt;
                ones_q           <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cassette_record.sv
// Bench for cassette_record: synthesises FSK tape audio for random bytes and
// compares every SDRAM write, flag and status against a byte-level model.
module tb_cassette_record;

    localparam int S_PER = 66;
    localparam int L_PER = 133;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       rewind;
    logic       cas_in;
    logic       carrier;
    logic       frame_err;
    logic       overflow;
    logic [2:0] status;

    cassette_record_if bus ();

    cassette_record #(
        .MIN_PER      (20),
        .THRESH       (100),
        .MAX_PER      (200),
        .CARRIER_BITS (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .rewind    (rewind),
        .cas_in    (cas_in),
        .sdram     (bus),
        .carrier   (carrier),
        .frame_err (frame_err),
        .overflow  (overflow),
        .status    (status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Byte-level reference model
    logic [24:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    logic [24:0] m_addr = '0;
    logic        m_held = 1'b0;
    logic [7:0]  m_held_data = 8'd0;
    logic        m_ovf = 1'b0;
    bit          ack_en = 1'b1;
    int          ferr_cnt = 0;
    int          wr_cnt = 0;
    int          age = 0;
    int          dly = 2;

    task automatic model_byte(input logic [7:0] d);
        if (ack_en) begin
            exp_addr.push_back(m_addr);
            exp_data.push_back(d);
            m_addr = m_addr + 25'd1;
        end else if (!m_held) begin
            m_held      = 1'b1;
            m_held_data = d;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    // Arbiter stand-in: acks each write after a random delay and checks it
    initial begin
        bus.sdram_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_err) ferr_cnt++;
            bus.sdram_ack = 1'b0;
            if (bus.sdram_wr && ack_en) begin
                if (age >= dly) begin
                    bus.sdram_ack = 1'b1;
                    wr_cnt++;
                    check_eq("wr_expected", 32'(exp_addr.size() > 0), 32'd1);
                    if (exp_addr.size() > 0) begin
                        check_eq("wr_addr", 32'(bus.sdram_addr), 32'(exp_addr.pop_front()));
                        check_eq("wr_data", 32'(bus.sdram_dout), 32'(exp_data.pop_front()));
                    end
                    age = 0;
                    dly = int'($urandom_range(0, 4));
                end else begin
                    age++;
                end
            end else begin
                age = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cyc(input int per);
        cas_in = 1'b1;
        tick(per / 2);
        cas_in = 1'b0;
        tick(per - per / 2);
    endtask

    // 1200 Hz cycle with a brief dip just after its rising edge
    task automatic glitch_cyc();
        cas_in = 1'b1;
        tick(5);
        cas_in = 1'b0;
        tick(3);
        cas_in = 1'b1;
        tick(58);
        cas_in = 1'b0;
        tick(67);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        if (b) begin
            cyc(S_PER);
            cyc(S_PER);
        end else if (glitch) begin
            glitch_cyc();
        end else begin
            cyc(L_PER);
        end
    endtask

    // Start bit, 8 data LSB-first, stop bit, then two idle 1 bits so the
    // stop bit's period gets closed by a following rising edge
    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_idx);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], i == glitch_idx);
        send_bit(stop, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
    endtask

    task automatic leader(input int n);
        cas_in = 1'b0;
        tick(250);
        for (int i = 0; i < n; i++) send_bit(1'b1, 1'b0);
    endtask

    task automatic good_byte(input logic [7:0] d, input int glitch_idx);
        model_byte(d);
        send_frame(d, 1'b1, glitch_idx);
    endtask

    initial begin
        int f0;
        int w0;
        logic [7:0] b;

        reset  = 1'b1;
        en     = 1'b1;
        rewind = 1'b0;
        cas_in = 1'b0;
        tick(3);
        check_eq("rst_addr", 32'(bus.sdram_addr), 32'd0);
        check_eq("rst_dout", 32'(bus.sdram_dout), 32'd0);
        check_eq("rst_wr", 32'(bus.sdram_wr), 32'd0);
        check_eq("rst_ferr", 32'(frame_err), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_carrier", 32'(carrier), 32'd0);
        check_eq("rst_status", 32'(status), 32'd0);
        reset = 1'b0;
        tick(2);

        // Normal bytes: 0xA5 then random data with random ack latency
        f0 = ferr_cnt;
        leader(int'($urandom_range(17, 20)));
        check_eq("leader_carrier", 32'(carrier), 32'd1);
        check_eq("leader_status", 32'(status), 32'd1);
        good_byte(8'hA5, -1);
        check_eq("a5_addr", 32'(bus.sdram_addr), 32'(m_addr));
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            good_byte(b, -1);
        end
        check_eq("rand_addr", 32'(bus.sdram_addr), 32'(m_addr));
        check_eq("rand_carrier", 32'(carrier), 32'd1);
        check_eq("rand_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Bad stop bit
        f0 = ferr_cnt;
        w0 = wr_cnt;
        leader(18);
        send_frame(8'h3C, 1'b0, -1);
        tick(5);
        check_eq("badstop_ferr", 32'(ferr_cnt - f0), 32'd1);
        check_eq("badstop_status", 32'(status), 32'd0);
        check_eq("badstop_nowr", 32'(wr_cnt - w0), 32'd0);

        // Carrier loss mid-byte
        w0 = wr_cnt;
        leader(18);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check_eq("loss_data", 32'(status), 32'd2);
        cas_in = 1'b0;
        tick(250);
        check_eq("loss_status", 32'(status), 32'd0);
        check_eq("loss_carrier", 32'(carrier), 32'd0);
        check_eq("loss_nowr", 32'(wr_cnt - w0), 32'd0);

        // Glitch inside a 1200 Hz cycle
        f0 = ferr_cnt;
        leader(18);
        good_byte(8'h81, 1);
        check_eq("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        check_eq("glitch_addr", 32'(bus.sdram_addr), 32'(m_addr));

        // Overflow with ack withheld
        ack_en = 1'b0;
        leader(18);
        good_byte(8'h11, -1);
        good_byte(8'h22, -1);
        check_eq("ovf_dout", 32'(bus.sdram_dout), 32'(m_held_data));
        check_eq("ovf_flag", 32'(overflow), 32'(m_ovf));
        check_eq("ovf_wr", 32'(bus.sdram_wr), 32'(m_held));
        check_eq("ovf_addr", 32'(bus.sdram_addr), 32'(m_addr));
        exp_addr.push_back(m_addr);
        exp_data.push_back(m_held_data);
        m_addr = m_addr + 25'd1;
        m_held = 1'b0;
        ack_en = 1'b1;
        tick(10);
        check_eq("ovf_ack_addr", 32'(bus.sdram_addr), 32'(m_addr));
        check_eq("ovf_sticky", 32'(overflow), 32'(m_ovf));

        // Rewind after three more bytes
        leader(18);
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            good_byte(b, -1);
        end
        check_eq("pre_rew_addr", 32'(bus.sdram_addr), 32'(m_addr));
        rewind = ~rewind;
        m_addr = '0;
        m_ovf  = 1'b0;
        tick(3);
        check_eq("rew_addr", 32'(bus.sdram_addr), 32'(m_addr));
        check_eq("rew_ovf", 32'(overflow), 32'(m_ovf));
        check_eq("rew_status", 32'(status), 32'd0);
        leader(18);
        b = 8'($urandom);
        good_byte(b, -1);
        check_eq("post_rew_addr", 32'(bus.sdram_addr), 32'(m_addr));

        tick(20);
        check_eq("exp_drained", 32'(exp_addr.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
